// File: rtl/ppm_tx_frame_ctrl.sv
// ppm_tx_frame_ctrl: PPM TX frame sequencer (RAM fetch + one-byte prefetch to serializer); optional preamble when PPM_TX_PREAMBLE_EN is defined
module ppm_tx_frame_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LEN_W = 10,
  parameter int RD_LAT = 2,
  parameter int STROBE_DLY = 3
`ifdef PPM_TX_PREAMBLE_EN
  ,
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
  parameter int PREAMBLE_LEN = 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_rd_data,
  output logic [7:0]        o_ser_data,
  output logic              o_ser_strobe,
  input  logic              i_ser_done
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_LOAD = 3'd2, S_PREF = 3'd3,
                         S_HOLD = 3'd4, S_DLY = 3'd5, S_TAIL = 3'd6;
  localparam int CW = $clog2(STROBE_DLY + 1);
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic [7:0]        r_buf;
  logic              r_full;
  logic [CW-1:0]     r_cnt;
  logic [RD_LAT-1:0] r_pipe;
  logic              w_vld;
`ifdef PPM_TX_PREAMBLE_EN
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  logic [PW-1:0]     r_pre;
`endif
  assign w_vld = r_pipe[RD_LAT-1];
  // Read tokens ride this shift register so the data beat is known exactly RD_LAT cycles after each read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pipe <= '0;
    else r_pipe <= i_abort ? '0 : RD_LAT'({r_pipe, o_mem_rd_en});
  // Frame FSM: r_addr/r_rem track the next unread byte, r_buf holds the prefetched byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_rem        <= '0;
      r_buf        <= '0;
      r_full       <= 1'b0;
      r_cnt        <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_mem_rd_en  <= 1'b0;
      o_mem_addr   <= '0;
      o_ser_data   <= '0;
      o_ser_strobe <= 1'b0;
`ifdef PPM_TX_PREAMBLE_EN
      r_pre        <= '0;
`endif
    end else if (i_abort) begin
      r_state      <= S_IDLE;
      r_full       <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_mem_rd_en  <= 1'b0;
      o_ser_strobe <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_mem_rd_en  <= 1'b0;
      o_ser_strobe <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
`ifdef PPM_TX_PREAMBLE_EN
          o_busy       <= 1'b1;
          o_ser_strobe <= 1'b1;
          o_ser_data   <= PREAMBLE_BYTE;
          r_pre        <= PW'(PREAMBLE_LEN - 1);
          r_addr       <= i_base_addr;
          r_rem        <= i_length;
          r_state      <= S_LOAD;
`else
          if (i_length != '0) begin
            o_busy      <= 1'b1;
            o_mem_rd_en <= 1'b1;
            o_mem_addr  <= i_base_addr;
            r_addr      <= i_base_addr + ADDR_W'(1);
            r_rem       <= i_length - LEN_W'(1);
            r_state     <= S_FETCH;
          end else begin
            o_done  <= 1'b1;
            r_state <= S_TAIL;
          end
`endif
        end
        S_FETCH: if (w_vld) begin
          o_ser_strobe <= 1'b1;
          o_ser_data   <= i_mem_rd_data;
          r_state      <= S_LOAD;
        end
        S_LOAD: begin
`ifdef PPM_TX_PREAMBLE_EN
          if (r_pre != '0) begin
            r_buf   <= PREAMBLE_BYTE;
            r_full  <= 1'b1;
            r_pre   <= r_pre - PW'(1);
            r_state <= S_HOLD;
          end else
`endif
          if (r_rem != '0) begin
            o_mem_rd_en <= 1'b1;
            o_mem_addr  <= r_addr;
            r_addr      <= r_addr + ADDR_W'(1);
            r_rem       <= r_rem - LEN_W'(1);
            r_state     <= S_PREF;
          end else r_state <= S_HOLD;
        end
        S_PREF: if (w_vld) begin
          r_buf   <= i_mem_rd_data;
          r_full  <= 1'b1;
          r_state <= S_HOLD;
        end
        S_HOLD: if (i_ser_done) begin
          r_cnt   <= CW'(STROBE_DLY - 1);
          r_state <= S_DLY;
        end
        S_DLY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            if (r_full) begin
              o_ser_strobe <= 1'b1;
              o_ser_data   <= r_buf;
              r_full       <= 1'b0;
              r_state      <= S_LOAD;
            end else begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              r_state <= S_TAIL;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ppm_tx_frame_ctrl.sv
// tb_ppm_tx_frame_ctrl: randomized self-checking bench for ppm_tx_frame_ctrl against a frame-level model
module tb_ppm_tx_frame_ctrl;
  localparam int SDLY = 3;
`ifdef PPM_TX_PREAMBLE_EN
  localparam int PRE_N = 2;
`else
  localparam int PRE_N = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_abort = 1'b0, i_ser_done = 1'b0;
  logic [9:0] i_base_addr = '0, i_length = '0;
  logic o_busy, o_done, o_mem_rd_en, o_ser_strobe;
  logic [9:0] o_mem_addr;
  logic [7:0] i_mem_rd_data, o_ser_data, rd_q1;
  logic [7:0] mem [1024];
  int npass = 0, ntot = 0;
  int obs_addr[$], obs_byte[$], obs_scyc[$], obs_dcyc[$], sd_cyc[$];
  int late_ev, abort_cyc, ab_busy, done_busy;

  ppm_tx_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_length(i_length), .o_busy(o_busy), .o_done(o_done),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr), .i_mem_rd_data(i_mem_rd_data),
    .o_ser_data(o_ser_data), .o_ser_strobe(o_ser_strobe), .i_ser_done(i_ser_done)
  );

  always #5 clk = ~clk;

  // two-cycle RAM; random garbage on the bus whenever no read is in flight
  always @(posedge clk) begin
    rd_q1 <= o_mem_rd_en ? mem[o_mem_addr] : 8'($urandom);
    i_mem_rd_data <= rd_q1;
  end

  function automatic int exp_byte(input int base, input int i);
    return (i < PRE_N) ? 32'h55 : int'(mem[(base + i - PRE_N) % 1024]);
  endfunction

  // drives one frame and plays the serializer; records everything observed
  task automatic run_frame(input logic [9:0] base, input logic [9:0] len, input int abort_dly, input int restart_dly);
    int t = 0, nd = -1, end_t = 3000, rs = -1;
    obs_addr.delete(); obs_byte.delete(); obs_scyc.delete(); obs_dcyc.delete(); sd_cyc.delete();
    late_ev = 0; abort_cyc = -1; ab_busy = -1; done_busy = -1;
    @(negedge clk);
    i_start = 1'b1; i_base_addr = base; i_length = len;
    while (t < end_t) begin
      @(negedge clk);
      t++;
      i_start = 1'b0; i_abort = 1'b0; i_ser_done = 1'b0;
      if (abort_cyc >= 0 && t > abort_cyc && (o_mem_rd_en || o_ser_strobe || o_done)) late_ev++;
      if (t == abort_cyc + 1) ab_busy = int'(o_busy);
      if (o_mem_rd_en) obs_addr.push_back(int'(o_mem_addr));
      if (o_ser_strobe) begin
        obs_byte.push_back(int'(o_ser_data));
        obs_scyc.push_back(t);
        nd = t + int'($urandom_range(6, 14));
        if (obs_byte.size() == 2 && abort_dly >= 0) abort_cyc = t + abort_dly;
        if (obs_byte.size() == 1 && restart_dly >= 0) rs = t + restart_dly;
      end
      if (o_done) begin
        obs_dcyc.push_back(t);
        done_busy = int'(o_busy);
        if (end_t > t + 20) end_t = t + 20;
      end
      if (t == nd) begin i_ser_done = 1'b1; sd_cyc.push_back(t); end
      if (t == abort_cyc) begin i_abort = 1'b1; end_t = t + 40; end
      if (t == rs) begin
        i_start = 1'b1; i_base_addr = 10'($urandom); i_length = 10'($urandom_range(1, 1023));
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    ntot++;
    if ({o_busy, o_done, o_mem_rd_en, o_ser_strobe, o_mem_addr, o_ser_data} !== 22'd0)
      $display("FAIL reset_outputs: got %h want 0", {o_busy, o_done, o_mem_rd_en, o_ser_strobe, o_mem_addr, o_ser_data});
    else npass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ntot++;
    if ({o_busy, o_done, o_mem_rd_en, o_ser_strobe} !== 4'd0)
      $display("FAIL idle_after_reset: got %b want 0000", {o_busy, o_done, o_mem_rd_en, o_ser_strobe});
    else npass++;
  endtask

  task automatic test_frames;
    logic [9:0] base, len;
    int n, got, want;
    for (int k = 0; k < 8; k++) begin
      base = (k == 0) ? 10'h010 : (k == 1) ? 10'h3FE : 10'($urandom);
      len  = (k == 0) ? 10'd1 : (k == 1) ? 10'd4 : 10'($urandom_range(1, 6));
      run_frame(base, len, -1, -1);
      n = PRE_N + int'(len);
      ntot++;
      if (obs_byte.size() !== n) $display("FAIL strobe_count f%0d: got %0d want %0d", k, obs_byte.size(), n);
      else npass++;
      for (int i = 0; i < n; i++) begin
        got = (i < obs_byte.size()) ? obs_byte[i] : -1;
        want = exp_byte(int'(base), i);
        ntot++;
        if (got !== want) $display("FAIL ser_data f%0d b%0d: got %0h want %0h", k, i, got, want);
        else npass++;
      end
      for (int i = 1; i < n; i++) begin
        got = (i < obs_scyc.size()) ? obs_scyc[i] : -1;
        want = (i - 1 < sd_cyc.size()) ? sd_cyc[i - 1] + SDLY : -2;
        ntot++;
        if (got !== want) $display("FAIL strobe_timing f%0d b%0d: got cycle %0d want %0d", k, i, got, want);
        else npass++;
      end
      ntot++;
      if (obs_addr.size() !== int'(len)) $display("FAIL read_count f%0d: got %0d want %0d", k, obs_addr.size(), len);
      else npass++;
      for (int i = 0; i < int'(len); i++) begin
        got = (i < obs_addr.size()) ? obs_addr[i] : -1;
        want = (int'(base) + i) % 1024;
        ntot++;
        if (got !== want) $display("FAIL read_addr f%0d r%0d: got %0h want %0h", k, i, got, want);
        else npass++;
      end
      ntot++;
      if (obs_dcyc.size() !== 1) $display("FAIL done_count f%0d: got %0d want 1", k, obs_dcyc.size());
      else npass++;
      got = (obs_dcyc.size() > 0) ? obs_dcyc[0] : -1;
      want = (sd_cyc.size() >= n) ? sd_cyc[n - 1] + SDLY : -2;
      ntot++;
      if (got !== want) $display("FAIL done_timing f%0d: got cycle %0d want %0d", k, got, want);
      else npass++;
      ntot++;
      if (done_busy !== 0) $display("FAIL busy_at_done f%0d: got %0d want 0", k, done_busy);
      else npass++;
    end
  endtask

  task automatic test_zero_len;
    int got, want;
    run_frame(10'($urandom), 10'd0, -1, -1);
    ntot++;
    if (obs_addr.size() !== 0) $display("FAIL zero_len_reads: got %0d want 0", obs_addr.size());
    else npass++;
    ntot++;
    if (obs_byte.size() !== PRE_N) $display("FAIL zero_len_strobes: got %0d want %0d", obs_byte.size(), PRE_N);
    else npass++;
    ntot++;
    if (obs_dcyc.size() !== 1) $display("FAIL zero_len_done_count: got %0d want 1", obs_dcyc.size());
    else npass++;
    got = (obs_dcyc.size() > 0) ? obs_dcyc[0] : -1;
    want = (PRE_N == 0) ? 1 : (sd_cyc.size() >= PRE_N) ? sd_cyc[PRE_N - 1] + SDLY : -2;
    ntot++;
    if (got !== want) $display("FAIL zero_len_done_timing: got cycle %0d want %0d", got, want);
    else npass++;
  endtask

  task automatic test_abort;
    logic [9:0] base;
    int got;
    base = 10'($urandom);
    run_frame(base, 10'd5, 10, -1);
    ntot++;
    if (ab_busy !== 0) $display("FAIL abort_busy: got %0d want 0", ab_busy);
    else npass++;
    ntot++;
    if (late_ev !== 0) $display("FAIL abort_late_events: got %0d want 0", late_ev);
    else npass++;
    ntot++;
    if (obs_dcyc.size() !== 0) $display("FAIL abort_done: got %0d want 0", obs_dcyc.size());
    else npass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < obs_byte.size()) ? obs_byte[i] : -1;
      ntot++;
      if (got !== exp_byte(int'(base), i)) $display("FAIL abort_prefix b%0d: got %0h want %0h", i, got, exp_byte(int'(base), i));
      else npass++;
    end
    base = 10'($urandom);
    run_frame(base, 10'd3, -1, -1);
    ntot++;
    if (obs_byte.size() !== PRE_N + 3) $display("FAIL post_abort_strobes: got %0d want %0d", obs_byte.size(), PRE_N + 3);
    else npass++;
    for (int i = 0; i < PRE_N + 3; i++) begin
      got = (i < obs_byte.size()) ? obs_byte[i] : -1;
      ntot++;
      if (got !== exp_byte(int'(base), i)) $display("FAIL post_abort_data b%0d: got %0h want %0h", i, got, exp_byte(int'(base), i));
      else npass++;
    end
    ntot++;
    if (obs_dcyc.size() !== 1) $display("FAIL post_abort_done: got %0d want 1", obs_dcyc.size());
    else npass++;
  endtask

  task automatic test_start_ignored;
    logic [9:0] base;
    int ev, got;
    base = 10'($urandom);
    run_frame(base, 10'd4, -1, 3);
    ntot++;
    if (obs_addr.size() !== 4) $display("FAIL restart_reads: got %0d want 4", obs_addr.size());
    else npass++;
    for (int i = 0; i < PRE_N + 4; i++) begin
      got = (i < obs_byte.size()) ? obs_byte[i] : -1;
      ntot++;
      if (got !== exp_byte(int'(base), i)) $display("FAIL restart_data b%0d: got %0h want %0h", i, got, exp_byte(int'(base), i));
      else npass++;
    end
    ntot++;
    if (obs_dcyc.size() !== 1) $display("FAIL restart_done: got %0d want 1", obs_dcyc.size());
    else npass++;
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1; i_length = 10'd5; i_base_addr = 10'($urandom);
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    ev = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_busy || o_mem_rd_en || o_ser_strobe || o_done) ev++;
      @(negedge clk);
    end
    ntot++;
    if (ev !== 0) $display("FAIL start_abort_same_cycle: got %0d active cycles want 0", ev);
    else npass++;
    base = 10'($urandom);
    run_frame(base, 10'd2, -1, -1);
    for (int i = 0; i < 2; i++) begin
      got = (i < obs_addr.size()) ? obs_addr[i] : -1;
      ntot++;
      if (got !== (int'(base) + i) % 1024) $display("FAIL after_ignore_addr r%0d: got %0h want %0h", i, got, (int'(base) + i) % 1024);
      else npass++;
    end
  endtask

  task automatic test_reset_mid;
    int ev = 0, seen = 0;
    @(negedge clk);
    i_start = 1'b1; i_base_addr = 10'($urandom); i_length = 10'd6;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_ser_strobe) seen = 1;
    end
    ntot++;
    if (seen !== 1) $display("FAIL reset_mid_first_strobe: got %0d want 1", seen);
    else npass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ntot++;
    if ({o_busy, o_done, o_mem_rd_en, o_ser_strobe, o_mem_addr, o_ser_data} !== 22'd0)
      $display("FAIL reset_mid_async: got %h want 0", {o_busy, o_done, o_mem_rd_en, o_ser_strobe, o_mem_addr, o_ser_data});
    else npass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_busy || o_ser_strobe || o_done) ev++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_busy || o_ser_strobe || o_done) ev++;
    end
    ntot++;
    if (ev !== 0) $display("FAIL reset_mid_quiet: got %0d active cycles want 0", ev);
    else npass++;
    run_frame(10'($urandom), 10'd2, -1, -1);
    ntot++;
    if (obs_dcyc.size() !== 1) $display("FAIL reset_mid_recover: got %0d dones want 1", obs_dcyc.size());
    else npass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h010] = 8'hA5;
    mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[10'h000] = 8'h33; mem[10'h001] = 8'h44;
    test_reset;
    test_frames;
    test_zero_len;
    test_abort;
    test_start_ignored;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
